depar_out_demux: RTL and testbench

- Output stage directly downstream of the deparser. Consumes the deparser's AXI4-Stream output and steers each packet to one or more physical output ports.
- Steering uses the one-hot destination-port field in tuser of the first beat; that field is held for the whole packet.
- Provides one registered output slice per port, with multicast and packet-drop support.

---
 rtl/depar_out_demux_pkg.sv | 16 +
 rtl/depar_out_demux_if.sv | 40 ++++
 rtl/depar_out_slice.sv | 47 ++++
 rtl/depar_out_demux.sv | 129 ++++++++++++
 tb/tb_depar_out_demux.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/depar_out_demux_pkg.sv
// Shared definitions for the deparser output demux: FSM encoding,
// destination-port field layout and statistics counter width.
package depar_out_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Port i is selected by tuser bit (C_DST_PORT_POS + DST_PORT_STRIDE*i);
  // the odd bits in between belong to DMA queues and are not ports.
  localparam int DST_PORT_STRIDE = 2;
  localparam int CNT_W           = 32;

endpackage

// File: rtl/depar_out_demux_if.sv
// Stream bundle for the demux: one input stream from the deparser and
// C_NUM_PORTS flattened output streams (port i occupies slice i).
interface depar_out_demux_if #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_PORTS        = 4
);
  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

  logic [C_AXIS_DATA_WIDTH-1:0]              s_axis_tdata;
  logic [KEEP_W-1:0]                         s_axis_tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0]             s_axis_tuser;
  logic                                      s_axis_tvalid;
  logic                                      s_axis_tlast;
  logic                                      s_axis_tready;

  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]  m_axis_tdata;
  logic [C_NUM_PORTS*KEEP_W-1:0]             m_axis_tkeep;
  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser;
  logic [C_NUM_PORTS-1:0]                    m_axis_tvalid;
  logic [C_NUM_PORTS-1:0]                    m_axis_tlast;
  logic [C_NUM_PORTS-1:0]                    m_axis_tready;

  // Demux side: consumes the input stream, drives the output streams.
  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  // Environment side: produces the input stream, sinks the output streams.
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/depar_out_slice.sv
// Single-port registered output slice: one beat of storage with
// load/valid/ready handshake; a drain and a load in the same cycle
// keep the slice full with the new beat.
module depar_out_slice #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int USER_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic [USER_W-1:0] in_user,
  input  logic              in_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [KEEP_W-1:0] keep,
  output logic [USER_W-1:0] user,
  output logic              last,
  output logic              can_load
);

  // The slice can accept a beat when empty or when its beat leaves this cycle.
  assign can_load = ~valid | ready;

  // Beat register: load has priority over drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
      user  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      keep  <= in_keep;
      user  <= in_user;
      last  <= in_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/depar_out_demux.sv
// Deparser output demux: steers each packet to the one-hot set of ports
// named in the first beat's tuser, with lock-step multicast and drop of
// packets that select no existing port.
module depar_out_demux
  import depar_out_demux_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_PORTS        = 4,
  parameter int C_DST_PORT_POS     = 24
) (
  input  logic               axis_clk,
  input  logic               reset,
  depar_out_demux_if.slave   bus,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

  state_t                   state;
  logic [C_NUM_PORTS-1:0]   sel_r;
  logic [C_NUM_PORTS-1:0]   sel_now;
  logic [C_NUM_PORTS-1:0]   can_load;
  logic [C_NUM_PORTS-1:0]   load;
  logic                     accept;
  logic [CNT_W-1:0]         pkt_q;
  logic [CNT_W-1:0]         drop_q;

  logic [C_NUM_PORTS-1:0]                         slice_valid;
  logic [C_NUM_PORTS-1:0]                         slice_last;
  logic [C_NUM_PORTS-1:0][C_AXIS_DATA_WIDTH-1:0]  slice_data;
  logic [C_NUM_PORTS-1:0][KEEP_W-1:0]             slice_keep;
  logic [C_NUM_PORTS-1:0][C_AXIS_TUSER_WIDTH-1:0] slice_user;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Destination set: live from tuser on a first beat, latched value mid-packet,
  // empty while discarding so nothing loads and the input is never stalled.
  always_comb begin
    sel_now = '0;
    for (int i = 0; i < C_NUM_PORTS; i++) begin
      if (state == ST_IDLE) begin
        sel_now[i] = bus.s_axis_tuser[C_DST_PORT_POS + DST_PORT_STRIDE*i];
      end else if (state == ST_FWD) begin
        sel_now[i] = sel_r[i];
      end
    end
  end

  // All selected ports must take the beat together; unselected ports don't matter.
  assign bus.s_axis_tready = ~reset & (&(can_load | ~sel_now));
  assign accept            = bus.s_axis_tvalid & bus.s_axis_tready;
  assign load              = {C_NUM_PORTS{accept}} & sel_now;

  // Packet FSM and saturating packet/drop statistics.
  always_ff @(posedge axis_clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      sel_r  <= '0;
      pkt_q  <= '0;
      drop_q <= '0;
    end else if (accept) begin
      unique case (state)
        ST_IDLE: begin
          if (|sel_now) begin
            if (bus.s_axis_tlast) begin
              pkt_q <= sat_inc(pkt_q);
            end else begin
              state <= ST_FWD;
              sel_r <= sel_now;
            end
          end else begin
            if (bus.s_axis_tlast) drop_q <= sat_inc(drop_q);
            else                  state  <= ST_DROP;
          end
        end
        ST_FWD: begin
          if (bus.s_axis_tlast) begin
            state <= ST_IDLE;
            pkt_q <= sat_inc(pkt_q);
          end
        end
        ST_DROP: begin
          if (bus.s_axis_tlast) begin
            state  <= ST_IDLE;
            drop_q <= sat_inc(drop_q);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pkt_cnt  = pkt_q;
  assign drop_cnt = drop_q;

  for (genvar g = 0; g < C_NUM_PORTS; g++) begin : g_port
    depar_out_slice #(
      .DATA_W (C_AXIS_DATA_WIDTH),
      .KEEP_W (KEEP_W),
      .USER_W (C_AXIS_TUSER_WIDTH)
    ) u_slice (
      .clk      (axis_clk),
      .rst      (reset),
      .load     (load[g]),
      .in_data  (bus.s_axis_tdata),
      .in_keep  (bus.s_axis_tkeep),
      .in_user  (bus.s_axis_tuser),
      .in_last  (bus.s_axis_tlast),
      .ready    (bus.m_axis_tready[g]),
      .valid    (slice_valid[g]),
      .data     (slice_data[g]),
      .keep     (slice_keep[g]),
      .user     (slice_user[g]),
      .last     (slice_last[g]),
      .can_load (can_load[g])
    );
  end

  assign bus.m_axis_tvalid = slice_valid;
  assign bus.m_axis_tlast  = slice_last;
  assign bus.m_axis_tdata  = slice_data;
  assign bus.m_axis_tkeep  = slice_keep;
  assign bus.m_axis_tuser  = slice_user;

endmodule

// File: tb/tb_depar_out_demux.sv
// Bench for depar_out_demux: directed table of single-beat packets,
// hand-written multi-cycle sequences, and randomized traffic scored
// against a per-port expected-beat queue model.
module tb_depar_out_demux;

  localparam int DW  = 64;
  localparam int UW  = 128;
  localparam int NP  = 4;
  localparam int KW  = DW / 8;
  localparam int POS = 24;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    logic [7:0]    dst;
    logic [NP-1:0] exp_valid;
    int            pkt_inc;
    int            drop_inc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pkt_cnt;
  logic [31:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  bit          rand_rdy = 1'b0;
  bit          mon_en   = 1'b1;
  beat_t       exp_q[NP][$];
  bit          in_pkt = 1'b0;
  logic [NP-1:0] cur_mask = '0;
  logic [31:0] mdl_pkt = '0;
  logic [31:0] mdl_drop = '0;

  always #5 clk = ~clk;

  depar_out_demux_if #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .C_NUM_PORTS       (NP)
  ) bus ();

  depar_out_demux #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .C_NUM_PORTS       (NP),
    .C_DST_PORT_POS    (POS)
  ) dut (
    .axis_clk (clk),
    .reset    (reset),
    .bus      (bus),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NP-1:0] dst_mask(input logic [UW-1:0] u);
    logic [NP-1:0] m;
    for (int i = 0; i < NP; i++) m[i] = u[POS + 2*i];
    return m;
  endfunction

  function automatic logic [31:0] sat_add1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [UW-1:0] mk_user(input logic [7:0] dst);
    logic [UW-1:0] u;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[POS +: 8] = dst;
    return u;
  endfunction

  // Packet-level reference: beats are queued per destination port at the
  // input handshake and must come out of each port in order.
  task automatic monitor(input bit acc);
    beat_t b;
    beat_t got;
    if (reset) begin
      for (int i = 0; i < NP; i++) exp_q[i].delete();
      in_pkt   = 1'b0;
      mdl_pkt  = '0;
      mdl_drop = '0;
      return;
    end
    if (!mon_en) return;
    check("pkt_cnt_model", pkt_cnt, mdl_pkt);
    check("drop_cnt_model", drop_cnt, mdl_drop);
    for (int i = 0; i < NP; i++) begin
      if (bus.m_axis_tvalid[i] && bus.m_axis_tready[i]) begin
        got = {bus.m_axis_tdata[i*DW +: DW], bus.m_axis_tkeep[i*KW +: KW],
               bus.m_axis_tuser[i*UW +: UW], bus.m_axis_tlast[i]};
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL port%0d_unexpected_beat: got %0h expected no beat", i, got);
        end else begin
          b = exp_q[i].pop_front();
          check($sformatf("port%0d_beat", i), got, b);
        end
      end
    end
    if (acc) begin
      if (!in_pkt) begin
        cur_mask = dst_mask(bus.s_axis_tuser);
        in_pkt   = 1'b1;
      end
      b = {bus.s_axis_tdata, bus.s_axis_tkeep, bus.s_axis_tuser, bus.s_axis_tlast};
      for (int i = 0; i < NP; i++) if (cur_mask[i]) exp_q[i].push_back(b);
      if (bus.s_axis_tlast) begin
        in_pkt = 1'b0;
        if (cur_mask != '0) mdl_pkt  = sat_add1(mdl_pkt);
        else                mdl_drop = sat_add1(mdl_drop);
      end
    end
  endtask

  task automatic tick(output bit acc);
    @(negedge clk);
    acc = bus.s_axis_tvalid & bus.s_axis_tready & ~reset;
    monitor(acc);
    @(posedge clk);
    #1;
    if (rand_rdy) bus.m_axis_tready = NP'($urandom_range(0, (1 << NP) - 1));
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [UW-1:0] u,
                           input logic last, output int waits);
    bit acc;
    acc = 1'b0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = KW'($urandom);
    bus.s_axis_tuser  = u;
    bus.s_axis_tlast  = last;
    bus.s_axis_tvalid = 1'b1;
    waits = 0;
    for (int t = 0; t < 200; t++) begin
      tick(acc);
      if (acc) break;
      waits++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    bus.s_axis_tvalid = 1'b0;
    repeat (n) tick(acc);
  endtask

  task automatic do_reset();
    bit acc;
    reset = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    tick(acc);
    check("tready_in_reset", bus.s_axis_tready, 1'b0);
    check("valid_in_reset", bus.m_axis_tvalid, '0);
    tick(acc);
    reset = 1'b0;
    #1;
    check("tready_after_reset", bus.s_axis_tready, 1'b1);
    check("pkt_cnt_after_reset", pkt_cnt, 32'd0);
    check("drop_cnt_after_reset", drop_cnt, 32'd0);
  endtask

  initial begin
    vec_t          vecs[10];
    int            w;
    int            exp_pkt;
    int            exp_drop;
    bit            acc;
    logic [DW-1:0] d;
    logic [UW-1:0] u;

    vecs[0] = '{8'h01, 4'b0001, 1, 0};
    vecs[1] = '{8'h04, 4'b0010, 1, 0};
    vecs[2] = '{8'h10, 4'b0100, 1, 0};
    vecs[3] = '{8'h40, 4'b1000, 1, 0};
    vecs[4] = '{8'h55, 4'b1111, 1, 0};
    vecs[5] = '{8'h14, 4'b0110, 1, 0};
    vecs[6] = '{8'h41, 4'b1001, 1, 0};
    vecs[7] = '{8'h02, 4'b0000, 0, 1};
    vecs[8] = '{8'hAA, 4'b0000, 0, 1};
    vecs[9] = '{8'h00, 4'b0000, 0, 1};

    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tuser  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = '1;

    // Reset state
    do_reset();
    check("reset_tdata", bus.m_axis_tdata, '0);
    check("reset_tlast", bus.m_axis_tlast, '0);

    // Table of single-beat packets, all ports ready
    exp_pkt  = 0;
    exp_drop = 0;
    foreach (vecs[k]) begin
      d = {$urandom, $urandom};
      u = mk_user(vecs[k].dst);
      send_beat(d, u, 1'b1, w);
      check($sformatf("vec%0d_valid", k), bus.m_axis_tvalid, vecs[k].exp_valid);
      for (int i = 0; i < NP; i++)
        if (vecs[k].exp_valid[i]) check($sformatf("vec%0d_data_p%0d", k, i), bus.m_axis_tdata[i*DW +: DW], d);
      exp_pkt  += vecs[k].pkt_inc;
      exp_drop += vecs[k].drop_inc;
      check($sformatf("vec%0d_pkt_cnt", k), pkt_cnt, exp_pkt);
      check($sformatf("vec%0d_drop_cnt", k), drop_cnt, exp_drop);
    end
    idle(2);
    check("table_drained", bus.m_axis_tvalid, '0);

    // Unicast 3-beat packet to port1
    do_reset();
    for (int k = 0; k < 3; k++) begin
      d = {$urandom, $urandom};
      send_beat(d, mk_user(8'h04), (k == 2), w);
      check("uni_wait", w, 0);
      check("uni_valid", bus.m_axis_tvalid, 4'b0010);
      check("uni_last", bus.m_axis_tlast[1], (k == 2));
      check("uni_data", bus.m_axis_tdata[1*DW +: DW], d);
    end
    check("uni_pkt_cnt", pkt_cnt, 32'd1);
    idle(1);
    check("uni_idle_valid", bus.m_axis_tvalid, '0);

    // Multicast to ports 0 and 1 with port0 stalled for 5 cycles
    do_reset();
    send_beat({$urandom, $urandom}, mk_user(8'h05), 1'b0, w);
    check("mc_first_valid", bus.m_axis_tvalid, 4'b0011);
    bus.m_axis_tready = 4'b0010;
    d = {$urandom, $urandom};
    u = mk_user(8'h00);
    bus.s_axis_tdata  = d;
    bus.s_axis_tuser  = u;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(acc);
      check("mc_stall_no_accept", acc, 1'b0);
    end
    check("mc_stall_valid", bus.m_axis_tvalid, 4'b0001);
    bus.m_axis_tready = '1;
    send_beat(d, u, 1'b0, w);
    check("mc_resume_wait", w, 0);
    send_beat({$urandom, $urandom}, mk_user(8'h00), 1'b1, w);
    check("mc_last_valid", bus.m_axis_tvalid, 4'b0011);
    idle(2);
    check("mc_pkt_cnt", pkt_cnt, 32'd1);
    for (int i = 0; i < 2; i++) check($sformatf("mc_q%0d_empty", i), exp_q[i].size(), 0);

    // Drop of a 4-beat packet that names only a DMA bit, ports not ready
    do_reset();
    bus.m_axis_tready = '0;
    for (int k = 0; k < 4; k++) begin
      send_beat({$urandom, $urandom}, mk_user(8'h02), (k == 3), w);
      check("drop_wait", w, 0);
      check("drop_valid", bus.m_axis_tvalid, '0);
    end
    check("drop_drop_cnt", drop_cnt, 32'd1);
    check("drop_pkt_cnt", pkt_cnt, 32'd0);
    bus.m_axis_tready = '1;

    // Back-to-back: A to port2, then B to port3 whose later tuser is ignored
    do_reset();
    send_beat({$urandom, $urandom}, mk_user(8'h10), 1'b1, w);
    check("b2b_a_wait", w, 0);
    check("b2b_a_valid", bus.m_axis_tvalid, 4'b0100);
    send_beat({$urandom, $urandom}, mk_user(8'h40), 1'b0, w);
    check("b2b_b1_wait", w, 0);
    send_beat({$urandom, $urandom}, mk_user(8'h01), 1'b1, w);
    check("b2b_b2_wait", w, 0);
    check("b2b_b2_valid", bus.m_axis_tvalid, 4'b1000);
    check("b2b_pkt_cnt", pkt_cnt, 32'd2);
    idle(2);

    // Reset in the middle of a forwarded packet
    do_reset();
    send_beat({$urandom, $urandom}, mk_user(8'h01), 1'b1, w);
    send_beat({$urandom, $urandom}, mk_user(8'h04), 1'b0, w);
    check("rst_pre_pkt_cnt", pkt_cnt, 32'd1);
    bus.s_axis_tdata  = {$urandom, $urandom};
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = 1'b0;
    reset = 1'b1;
    tick(acc);
    check("rst_mid_valid", bus.m_axis_tvalid, '0);
    check("rst_mid_pkt_cnt", pkt_cnt, 32'd0);
    check("rst_mid_drop_cnt", drop_cnt, 32'd0);
    reset = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    idle(1);
    check("rst_mid_tready", bus.s_axis_tready, 1'b1);
    d = {$urandom, $urandom};
    send_beat(d, mk_user(8'h40), 1'b1, w);
    check("rst_fresh_valid", bus.m_axis_tvalid, 4'b1000);
    check("rst_fresh_data", bus.m_axis_tdata[3*DW +: DW], d);
    check("rst_fresh_pkt_cnt", pkt_cnt, 32'd1);
    idle(2);

    // Randomized traffic with random per-port backpressure
    do_reset();
    rand_rdy = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int   len;
      logic [7:0] dst;
      len = $urandom_range(1, 4);
      dst = 8'($urandom);
      for (int k = 0; k < len; k++)
        send_beat({$urandom, $urandom}, mk_user(k == 0 ? dst : 8'($urandom)), (k == len - 1), w);
      idle($urandom_range(0, 2));
    end
    rand_rdy = 1'b0;
    bus.m_axis_tready = '1;
    idle(6);
    for (int i = 0; i < NP; i++) check($sformatf("rand_q%0d_empty", i), exp_q[i].size(), 0);
    check("rand_valid_drained", bus.m_axis_tvalid, '0);

    // Packet counter saturation
    do_reset();
    mon_en = 1'b0;
    force dut.pkt_q = 32'hFFFF_FFFE;
    #1;
    release dut.pkt_q;
    check("sat_preset", pkt_cnt, 32'hFFFF_FFFE);
    send_beat({$urandom, $urandom}, mk_user(8'h01), 1'b1, w);
    check("sat_first", pkt_cnt, 32'hFFFF_FFFF);
    send_beat({$urandom, $urandom}, mk_user(8'h01), 1'b1, w);
    send_beat({$urandom, $urandom}, mk_user(8'h01), 1'b1, w);
    check("sat_hold", pkt_cnt, 32'hFFFF_FFFF);
    check("sat_drop_cnt", drop_cnt, 32'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
